// File: rtl/riscv_aes_block_regs_if.sv
// Operand-store bus for the AES block registers: core-side write port,
// per-bank clear/take controls and the full-contents read-back.
interface riscv_aes_block_regs_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 4,
    parameter int NUM_BANKS  = 2
);
    localparam int BW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int WW  = $clog2(NUM_WORDS);
    localparam int BEW = DATA_WIDTH / 8;

    logic                                      wen_i;
    logic [BW-1:0]                             wbank_i;
    logic [WW-1:0]                             waddr_i;
    logic                                      wauto_i;
    logic [DATA_WIDTH-1:0]                     wdata_i;
    logic [BEW-1:0]                            wbe_i;
    logic [NUM_BANKS-1:0]                      clear_i;
    logic [NUM_BANKS-1:0]                      take_i;
    logic [NUM_BANKS-1:0]                      valid_o;
    logic [NUM_BANKS*NUM_WORDS-1:0]            fill_o;
    logic [NUM_BANKS*NUM_WORDS*DATA_WIDTH-1:0] data_o;
    logic                                      wr_err_o;

    modport master (
        output wen_i, wbank_i, waddr_i, wauto_i, wdata_i, wbe_i, clear_i, take_i,
        input  valid_o, fill_o, data_o, wr_err_o
    );

    modport slave (
        input  wen_i, wbank_i, waddr_i, wauto_i, wdata_i, wbe_i, clear_i, take_i,
        output valid_o, fill_o, data_o, wr_err_o
    );
endinterface

// File: rtl/riscv_aes_block_regs.sv
// Multi-bank operand store for the AES unit. Each bank is filled one word
// per cycle (direct or auto-incrementing address, byte enables), reports
// valid once every word has been written, and is released by a take pulse.
// Sticky banks (the key) stay valid across takes so one key serves many
// blocks.
module riscv_aes_block_regs #(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   NUM_WORDS  = 4,
    parameter int                   NUM_BANKS  = 2,
    parameter logic [NUM_BANKS-1:0] STICKY     = 'b01
) (
    input logic                   clk,
    input logic                   rst,
    riscv_aes_block_regs_if.slave bus
);
    localparam int BW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int WW  = $clog2(NUM_WORDS);
    localparam int BEW = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q  [NUM_BANKS][NUM_WORDS];
    logic [NUM_WORDS-1:0]  fill_q [NUM_BANKS];
    logic [WW-1:0]         wptr_q [NUM_BANKS];
    logic                  wr_err_p1;

    logic [NUM_BANKS-1:0]  valid;
    logic [NUM_BANKS-1:0]  accept;
    logic [WW-1:0]         tgt [NUM_BANKS];
    logic                  reject_p0;

    // Replace only the byte lanes whose enable is set.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BEW-1:0]        be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int k = 0; k < BEW; k++) begin
            if (be[k]) begin
                r[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return r;
    endfunction

    // Per-bank write decode; an out-of-range bank index matches no bank and
    // therefore falls through to a rejection.
    always_comb begin
        reject_p0 = bus.wen_i;
        for (int b = 0; b < NUM_BANKS; b++) begin
            valid[b]  = &fill_q[b];
            tgt[b]    = bus.wauto_i ? wptr_q[b] : bus.waddr_i;
            accept[b] = bus.wen_i && (bus.wbank_i == BW'(b)) &&
                        !valid[b] && !bus.clear_i[b];
            if (accept[b]) begin
                reject_p0 = 1'b0;
            end
        end
    end

    // ---- stage p0 -> p1: bank state update (clear > take > write) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                fill_q[b] <= '0;
                wptr_q[b] <= '0;
                for (int w = 0; w < NUM_WORDS; w++) begin
                    mem_q[b][w] <= '0;
                end
            end
            wr_err_p1 <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bus.clear_i[b]) begin
                    fill_q[b] <= '0;
                    wptr_q[b] <= '0;
                    for (int w = 0; w < NUM_WORDS; w++) begin
                        mem_q[b][w] <= '0;
                    end
                end else if (bus.take_i[b] && valid[b]) begin
                    // Data is kept on take; only the bookkeeping is released.
                    if (!STICKY[b]) begin
                        fill_q[b] <= '0;
                        wptr_q[b] <= '0;
                    end
                end else if (accept[b]) begin
                    mem_q[b][tgt[b]] <= merge_bytes(mem_q[b][tgt[b]], bus.wdata_i, bus.wbe_i);
                    if (|bus.wbe_i) begin
                        fill_q[b][tgt[b]] <= 1'b1;
                    end
                    wptr_q[b] <= tgt[b] + WW'(1);
                end
            end
            wr_err_p1 <= reject_p0;
        end
    end

    // Flatten bank state onto the read-back buses.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bus.fill_o[b*NUM_WORDS +: NUM_WORDS] = fill_q[b];
            for (int w = 0; w < NUM_WORDS; w++) begin
                bus.data_o[(b*NUM_WORDS+w)*DATA_WIDTH +: DATA_WIDTH] = mem_q[b][w];
            end
        end
        bus.valid_o  = valid;
        bus.wr_err_o = wr_err_p1;
    end
endmodule
